io_interface_unit: RTL and testbench

//  Upstream I/O stage for the ALU: holds INPR (feeds alu_outdata path via inpr_outdata for code 1101),

---
 rtl/io_interface_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_io_interface_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_interface_unit.sv
// rtl/io_interface_unit.sv - I/O stage: INPR/OUTR, FGI/FGO/IEN flags, device handshakes, interrupt request
//
// Holds the keyboard input register (or an optional receive FIFO), the printer output
// register with its SEND/HOLD sequencer, the FGI/FGO/IEN flags, and executes the
// INP/OUT/SKI/SKO/ION/IOF/INT_ACK codes issued by the control unit.
//
// Optional feature macro: IO_RX_FIFO_EN (RX_FIFO_DEPTH-entry input FIFO replaces INPR).
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   io_code[2:0]                   I/O instruction from control unit
//   ac_outdata[7:0]                AC low byte, loaded into OUTR by OUT
//   dev_in_data/valid/ready        keyboard character stream
//   dev_out_data/valid/ready       printer character stream
//   inpr_outdata[7:0]              INPR (or FIFO head) to the ALU
//   fgi/fgo/ien_outdata            input flag, output flag, interrupt enable
//   skip_out                       one-cycle PC skip request from SKI/SKO
//   int_req                        ien & (fgi | fgo)

module io_interface_unit #(
    parameter int OUT_HOLD_CYCLES = 4,
    parameter int RX_FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] io_code,
    input  logic [7:0] ac_outdata,
    input  logic [7:0] dev_in_data,
    input  logic       dev_in_valid,
    output logic       dev_in_ready,
    output logic [7:0] dev_out_data,
    output logic       dev_out_valid,
    input  logic       dev_out_ready,
    output logic [7:0] inpr_outdata,
    output logic       fgi_outdata,
    output logic       fgo_outdata,
    output logic       ien_outdata,
    output logic       skip_out,
    output logic       int_req
);

    localparam logic [2:0] CODE_INP     = 3'b001;
    localparam logic [2:0] CODE_OUT     = 3'b010;
    localparam logic [2:0] CODE_SKI     = 3'b011;
    localparam logic [2:0] CODE_SKO     = 3'b100;
    localparam logic [2:0] CODE_ION     = 3'b101;
    localparam logic [2:0] CODE_IOF     = 3'b110;
    localparam logic [2:0] CODE_INT_ACK = 3'b111;

    localparam int              CW        = (OUT_HOLD_CYCLES > 1) ? $clog2(OUT_HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]   HOLD_LAST = CW'((OUT_HOLD_CYCLES > 0) ? OUT_HOLD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } out_state_t;

    logic is_inp;
    logic fgi;
    logic accept;

    assign is_inp = (io_code == CODE_INP);

    // ---------------------------------------------------------------- input path
`ifdef IO_RX_FIFO_EN
    localparam int PW = $clog2(RX_FIFO_DEPTH);

    logic [7:0]  mem_q [RX_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          full, empty, pop;

    assign full   = (count_q == (PW+1)'(RX_FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign dev_in_ready = ~full;
    assign accept = dev_in_valid & ~full;
    assign pop    = is_inp & ~empty;
    assign fgi    = ~empty;
    assign inpr_outdata = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !accept) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer widths equal log2(depth), so increment wraps modulo depth on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= dev_in_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end
`else
    logic [7:0] inpr_q, inpr_d;
    logic       fgi_q, fgi_d;

    assign dev_in_ready = ~fgi_q;
    assign accept       = dev_in_valid & ~fgi_q;
    assign fgi          = fgi_q;
    assign inpr_outdata = inpr_q;

    // A new character sets FGI even if INP is issued in the same cycle.
    always_comb begin
        inpr_d = inpr_q;
        fgi_d  = fgi_q;
        if (accept) begin
            inpr_d = dev_in_data;
            fgi_d  = 1'b1;
        end else if (is_inp) begin
            fgi_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inpr_q <= 8'h00;
            fgi_q  <= 1'b0;
        end else begin
            inpr_q <= inpr_d;
            fgi_q  <= fgi_d;
        end
    end
`endif

    // ---------------------------------------------------------------- output path
    out_state_t    state_q, state_d;
    logic [7:0]    outr_q, outr_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          fgo;

    // FGO is exactly "sequencer idle"; deriving it from the state register keeps them in lockstep.
    assign fgo           = (state_q == ST_IDLE);
    assign dev_out_valid = (state_q == ST_SEND);
    assign dev_out_data  = outr_q;

    always_comb begin
        state_d    = state_q;
        outr_d     = outr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (io_code == CODE_OUT) begin
                    outr_d  = ac_outdata;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (dev_out_ready) begin
                    hold_cnt_d = '0;
                    state_d    = (OUT_HOLD_CYCLES == 0) ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            outr_q     <= 8'h00;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            outr_q     <= outr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // ---------------------------------------------------------------- flags, skip, interrupt
    logic ien_q, ien_d;
    logic skip_q, skip_d;

    always_comb begin
        ien_d  = ien_q;
        skip_d = 1'b0;
        case (io_code)
            CODE_SKI:     skip_d = fgi;
            CODE_SKO:     skip_d = fgo;
            CODE_ION:     ien_d  = 1'b1;
            CODE_IOF:     ien_d  = 1'b0;
            CODE_INT_ACK: ien_d  = 1'b0;
            default:      ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ien_q  <= 1'b0;
            skip_q <= 1'b0;
        end else begin
            ien_q  <= ien_d;
            skip_q <= skip_d;
        end
    end

    assign fgi_outdata = fgi;
    assign fgo_outdata = fgo;
    assign ien_outdata = ien_q;
    assign skip_out    = skip_q;
    assign int_req     = ien_q & (fgi | fgo);

endmodule

// File: tb/tb_io_interface_unit.sv
// tb/tb_io_interface_unit.sv - directed self-checking bench for io_interface_unit
module tb_io_interface_unit;

    localparam logic [2:0] NOP = 3'b000, INP = 3'b001, OUT = 3'b010, SKI = 3'b011,
                           SKO = 3'b100, ION = 3'b101, IOF = 3'b110, ACK = 3'b111;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] io_code;
    logic [7:0] ac_outdata;
    logic [7:0] dev_in_data;
    logic       dev_in_valid;
    logic       dev_in_ready;
    logic [7:0] dev_out_data;
    logic       dev_out_valid;
    logic       dev_out_ready;
    logic [7:0] inpr_outdata;
    logic       fgi_outdata, fgo_outdata, ien_outdata, skip_out, int_req;

    int n_pass = 0;
    int n_total = 0;

    io_interface_unit #(.OUT_HOLD_CYCLES(4), .RX_FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .io_code(io_code), .ac_outdata(ac_outdata),
        .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid), .dev_in_ready(dev_in_ready),
        .dev_out_data(dev_out_data), .dev_out_valid(dev_out_valid), .dev_out_ready(dev_out_ready),
        .inpr_outdata(inpr_outdata), .fgi_outdata(fgi_outdata), .fgo_outdata(fgo_outdata),
        .ien_outdata(ien_outdata), .skip_out(skip_out), .int_req(int_req)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it; inputs are changed and outputs read here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_total++;
        if ({fgi_outdata, fgo_outdata, ien_outdata, dev_in_ready, dev_out_valid, int_req, skip_out} !== 7'b0101000)
            $display("FAIL reset_flags got fgi%b fgo%b ien%b rdy%b oval%b irq%b skip%b expected 0 1 0 1 0 0 0",
                     fgi_outdata, fgo_outdata, ien_outdata, dev_in_ready, dev_out_valid, int_req, skip_out);
        else n_pass++;
        n_total++;
        if (inpr_outdata !== 8'h00 || dev_out_data !== 8'h00)
            $display("FAIL reset_regs got inpr=%h outr=%h expected 00 00", inpr_outdata, dev_out_data);
        else n_pass++;
    endtask

    task automatic test_input();
        dev_in_data = 8'h41; dev_in_valid = 1'b1;
        tick();
        dev_in_valid = 1'b0;
        n_total++;
        if (fgi_outdata !== 1'b1 || inpr_outdata !== 8'h41 || dev_in_ready !== 1'b0)
            $display("FAIL input_accept got fgi=%b inpr=%h rdy=%b expected 1 41 0", fgi_outdata, inpr_outdata, dev_in_ready);
        else n_pass++;
        io_code = SKI;
        tick();
        io_code = NOP;
        n_total++;
        if (skip_out !== 1'b1) $display("FAIL ski_set got %b expected 1", skip_out);
        else n_pass++;
        tick();
        n_total++;
        if (skip_out !== 1'b0) $display("FAIL skip_pulse_width got %b expected 0", skip_out);
        else n_pass++;
        io_code = INP;
        tick();
        io_code = NOP;
        n_total++;
        if (fgi_outdata !== 1'b0 || dev_in_ready !== 1'b1 || inpr_outdata !== 8'h41)
            $display("FAIL inp_clear got fgi=%b rdy=%b inpr=%h expected 0 1 41", fgi_outdata, dev_in_ready, inpr_outdata);
        else n_pass++;
        io_code = SKI;
        tick();
        io_code = NOP;
        n_total++;
        if (skip_out !== 1'b0) $display("FAIL ski_clear got %b expected 0", skip_out);
        else n_pass++;
    endtask

    task automatic test_output();
        ac_outdata = 8'h5A; io_code = OUT;
        tick();
        io_code = NOP;
        n_total++;
        if (dev_out_data !== 8'h5A || dev_out_valid !== 1'b1 || fgo_outdata !== 1'b0)
            $display("FAIL out_start got data=%h val=%b fgo=%b expected 5a 1 0", dev_out_data, dev_out_valid, fgo_outdata);
        else n_pass++;
        io_code = SKO;
        tick();
        io_code = NOP;
        n_total++;
        if (skip_out !== 1'b0) $display("FAIL sko_busy got %b expected 0", skip_out);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (dev_out_valid !== 1'b1 || dev_out_data !== 8'h5A)
                $display("FAIL out_hold_valid cyc%0d got val=%b data=%h expected 1 5a", i, dev_out_valid, dev_out_data);
            else n_pass++;
        end
        dev_out_ready = 1'b1;
        tick();
        dev_out_ready = 1'b0;
        n_total++;
        if (dev_out_valid !== 1'b0 || fgo_outdata !== 1'b0)
            $display("FAIL out_handshake got val=%b fgo=%b expected 0 0", dev_out_valid, fgo_outdata);
        else n_pass++;
        // Busy window: FGO must rise on exactly the 4th edge after the handshake.
        ac_outdata = 8'h33; io_code = OUT;
        tick();
        io_code = NOP;
        n_total++;
        if (dev_out_data !== 8'h5A || dev_out_valid !== 1'b0 || fgo_outdata !== 1'b0)
            $display("FAIL out_ignored got data=%h val=%b fgo=%b expected 5a 0 0", dev_out_data, dev_out_valid, fgo_outdata);
        else n_pass++;
        for (int i = 2; i <= 4; i++) begin
            tick();
            n_total++;
            if (fgo_outdata !== (i == 4))
                $display("FAIL fgo_timing edge%0d got %b expected %b", i, fgo_outdata, (i == 4));
            else n_pass++;
        end
        io_code = SKO;
        tick();
        io_code = NOP;
        n_total++;
        if (skip_out !== 1'b1 || dev_out_valid !== 1'b0) $display("FAIL sko_idle got skip=%b val=%b expected 1 0", skip_out, dev_out_valid);
        else n_pass++;
    endtask

    task automatic test_interrupt();
        dev_in_data = 8'h7E; dev_in_valid = 1'b1;
        tick();
        dev_in_valid = 1'b0;
        n_total++;
        if (int_req !== 1'b0) $display("FAIL irq_no_ien got %b expected 0", int_req);
        else n_pass++;
        io_code = ION;
        tick();
        n_total++;
        if (ien_outdata !== 1'b1 || int_req !== 1'b1) $display("FAIL ion got ien=%b irq=%b expected 1 1", ien_outdata, int_req);
        else n_pass++;
        io_code = ACK;
        tick();
        n_total++;
        if (ien_outdata !== 1'b0 || int_req !== 1'b0) $display("FAIL int_ack got ien=%b irq=%b expected 0 0", ien_outdata, int_req);
        else n_pass++;
        io_code = IOF;
        tick();
        n_total++;
        if (ien_outdata !== 1'b0 || int_req !== 1'b0) $display("FAIL iof_idle got ien=%b irq=%b expected 0 0", ien_outdata, int_req);
        else n_pass++;
        io_code = ION;
        tick();
        io_code = IOF;
        tick();
        n_total++;
        if (ien_outdata !== 1'b0) $display("FAIL iof_clear got %b expected 0", ien_outdata);
        else n_pass++;
        io_code = INP;
        tick();
        io_code = NOP;
        n_total++;
        if (fgi_outdata !== 1'b0 || inpr_outdata !== 8'h7E) $display("FAIL inp_drain got fgi=%b inpr=%h expected 0 7e", fgi_outdata, inpr_outdata);
        else n_pass++;
    endtask

    task automatic test_reset_mid_send();
        ac_outdata = 8'hC3; io_code = OUT;
        tick();
        io_code = NOP;
        n_total++;
        if (dev_out_valid !== 1'b1) $display("FAIL pre_reset_send got %b expected 1", dev_out_valid);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if (dev_out_valid !== 1'b0 || fgo_outdata !== 1'b1 || dev_out_data !== 8'h00)
            $display("FAIL reset_mid_send got val=%b fgo=%b data=%h expected 0 1 00", dev_out_valid, fgo_outdata, dev_out_data);
        else n_pass++;
        ac_outdata = 8'h99; io_code = OUT;
        tick();
        io_code = NOP;
        n_total++;
        if (dev_out_valid !== 1'b1 || dev_out_data !== 8'h99)
            $display("FAIL out_after_reset got val=%b data=%h expected 1 99", dev_out_valid, dev_out_data);
        else n_pass++;
        dev_out_ready = 1'b1;
        tick();
        dev_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

`ifndef IO_RX_FIFO_EN
    task automatic test_accept_with_inp();
        dev_in_data = 8'h22; dev_in_valid = 1'b1; io_code = INP;
        tick();
        dev_in_valid = 1'b0; io_code = NOP;
        n_total++;
        if (fgi_outdata !== 1'b1 || inpr_outdata !== 8'h22)
            $display("FAIL accept_and_inp got fgi=%b inpr=%h expected 1 22", fgi_outdata, inpr_outdata);
        else n_pass++;
        dev_in_data = 8'h55; dev_in_valid = 1'b1;
        tick();
        dev_in_valid = 1'b0;
        n_total++;
        if (inpr_outdata !== 8'h22) $display("FAIL no_overwrite got inpr=%h expected 22", inpr_outdata);
        else n_pass++;
    endtask
`else
    task automatic test_fifo();
        logic [7:0] heads [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        dev_in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            dev_in_data = 8'(i);
            tick();
        end
        dev_in_valid = 1'b0;
        n_total++;
        if (dev_in_ready !== 1'b0 || fgi_outdata !== 1'b1 || inpr_outdata !== 8'h01)
            $display("FAIL fifo_full got rdy=%b fgi=%b head=%h expected 0 1 01", dev_in_ready, fgi_outdata, inpr_outdata);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (inpr_outdata !== heads[i]) $display("FAIL fifo_head%0d got %h expected %h", i, inpr_outdata, heads[i]);
            else n_pass++;
            io_code = INP;
            tick();
            io_code = NOP;
        end
        n_total++;
        if (fgi_outdata !== 1'b0 || inpr_outdata !== 8'h00 || dev_in_ready !== 1'b1)
            $display("FAIL fifo_empty got fgi=%b head=%h rdy=%b expected 0 00 1", fgi_outdata, inpr_outdata, dev_in_ready);
        else n_pass++;
        dev_in_data = 8'hAA; dev_in_valid = 1'b1;
        tick();
        dev_in_data = 8'hBB; io_code = INP;
        tick();
        dev_in_valid = 1'b0; io_code = NOP;
        n_total++;
        if (fgi_outdata !== 1'b1 || inpr_outdata !== 8'hBB)
            $display("FAIL fifo_push_pop got fgi=%b head=%h expected 1 bb", fgi_outdata, inpr_outdata);
        else n_pass++;
        io_code = INP;
        tick();
        io_code = NOP;
        n_total++;
        if (fgi_outdata !== 1'b0) $display("FAIL fifo_count_one got fgi=%b expected 0", fgi_outdata);
        else n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1; io_code = NOP; ac_outdata = 8'h00;
        dev_in_data = 8'h00; dev_in_valid = 1'b0; dev_out_ready = 1'b0;
        test_reset();
`ifndef IO_RX_FIFO_EN
        test_input();
        test_accept_with_inp();
        test_reset();
`else
        test_fifo();
`endif
        test_output();
        test_interrupt();
        test_reset_mid_send();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
